mem_access_unit: RTL

Initiator side of the CPU data-memory port. It accepts load/store requests from the datapath over a valid/ready handshake and buffers them in a small FIFO. It drives the synchronous single-port data memory (registered read, 1-cycle read latency, write on posedge) with mem_read/mem_write strobes, then returns each result over a valid/ready response channel. Sits between the execute stage and the 32 x 8 data memory.

---
 rtl/mau_pkg.sv | 23 ++
 rtl/mau_req_fifo.sv | 51 +++++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// Shared types and constants for the data-memory access unit.
package mau_pkg;

  localparam int unsigned MAU_ADDR_W    = 8;
  localparam int unsigned MAU_DATA_W    = 8;
  localparam int unsigned MAU_MEM_DEPTH = 32;

  localparam logic [MAU_DATA_W-1:0] ERR_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [MAU_ADDR_W-1:0] addr;
    logic [MAU_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mau_req_fifo.sv
// Synchronous request FIFO; power-of-2 depth, pointers wrap naturally.
module mau_req_fifo
  import mau_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic i_push,
  input  req_t i_data,
  input  logic i_pop,
  output req_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_head  = r_mem[r_rd_ptr];
    o_full  = (r_count == (PW+1)'(DEPTH));
    o_empty = (r_count == '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory port initiator: queues load/store requests, drives a 1-cycle-latency
// synchronous memory and returns results in order over a valid/ready channel.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned ADDR_W     = MAU_ADDR_W,
  parameter int unsigned DATA_W     = MAU_DATA_W,
  parameter int unsigned MEM_DEPTH  = MAU_MEM_DEPTH,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              busy
);

  state_t r_state;
  state_t w_next;

  req_t w_req;
  req_t w_head;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_head_err;

  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_error;

  always_comb begin
    w_req.write = req_write;
    w_req.addr  = req_addr;
    w_req.wdata = req_wdata;
  end

  assign w_push     = req_valid && !w_full;
  assign w_head_err = (32'(w_head.addr) >= MEM_DEPTH);

  mau_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .RST     (RST),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A head entry that is out of range skips ISSUE and lands straight in RESP,
  // including when it is popped on a response handshake.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = w_head_err ? RESP : ISSUE;
        end
      end
      ISSUE: w_next = r_mem_write ? RESP : WAIT;
      WAIT:  w_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = w_head_err ? RESP : ISSUE;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (r_state == RESP);
    busy      = !w_empty || (r_state != IDLE);
    req_ready = !w_full;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
    end else begin
      r_mem_read  <= w_pop && !w_head_err && !w_head.write;
      r_mem_write <= w_pop && !w_head_err &&  w_head.write;
      if (w_pop && !w_head_err) begin
        r_mem_address <= w_head.addr;
        r_mem_wdata   <= w_head.wdata;
      end
      if (w_pop && w_head_err) begin
        r_rsp_rdata <= ERR_DATA;
        r_rsp_error <= 1'b1;
      end else if (r_state == ISSUE && r_mem_write) begin
        r_rsp_rdata <= '0;
        r_rsp_error <= 1'b0;
      end else if (r_state == WAIT) begin
        r_rsp_rdata <= mem_rdata;
        r_rsp_error <= 1'b0;
      end
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;

endmodule
